// File: rtl/decode_hazard_scheduler.sv
// ---------------------------------------------------------------------------
// decode_hazard_scheduler
//
// Issue controller for the decode stage of the 16-bit pipeline. It keeps a
// small saturating counter of in-flight writes for each of the 16
// architectural registers. It stalls PC/IR and injects bubbles on RAW hazards
// and on write-count saturation. It sequences IR flushes after a redirect and
// counts hazard-stall cycles.
//
// Parameters
//   CNT_W              width of each per-register outstanding-write counter
//   FLUSH_CYCLES       cycles ir_flush is held after a redirect (1..15),
//                      including the request cycle
//   ZERO_REG_HARDWIRED r0 is never tracked and never causes a hazard
//   WB_BYPASS          a writeback retiring the last pending write to a
//                      source register satisfies that source in the same cycle
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   id_valid                      decode holds a valid instruction
//   id_rs1/id_rs2/id_rd           register fields of the decode instruction
//   id_use_rs1/id_use_rs2         instruction reads rs1 / rs2
//   id_write_rd                   instruction writes rd
//   wb_valid/wb_rd                a writer retires (or is squashed) this cycle
//   flush_req                     one-cycle redirect request from execute
//   pc_write/ir_write             PC / IR register enables
//   issue                         decode instruction advances this cycle
//   bubble                        insert a NOP into decode/execute
//   ir_flush                      clear IR to NOP
//   busy_vec                      bit i set while register i has writes in flight
//   stall_cycles                  saturating hazard-stall cycle count
//   state                         0=RUN, 1=STALL, 2=FLUSH
// ---------------------------------------------------------------------------
module decode_hazard_scheduler #(
    parameter int CNT_W              = 2,
    parameter int FLUSH_CYCLES       = 2,
    parameter bit ZERO_REG_HARDWIRED = 1'b1,
    parameter bit WB_BYPASS          = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [3:0]  id_rs1,
    input  logic [3:0]  id_rs2,
    input  logic [3:0]  id_rd,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic        id_write_rd,
    input  logic        wb_valid,
    input  logic [3:0]  wb_rd,
    input  logic        flush_req,
    output logic        pc_write,
    output logic        ir_write,
    output logic        issue,
    output logic        bubble,
    output logic        ir_flush,
    output logic [15:0] busy_vec,
    output logic [15:0] stall_cycles,
    output logic [1:0]  state
);

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
        $error("FLUSH_CYCLES must be in the range 1..15");
    end

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [3:0]       FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_flush_rem;
    logic [3:0]        w_flush_rem_nxt;
    logic [CNT_W-1:0]  r_cnt     [16];
    logic [CNT_W-1:0]  w_cnt_nxt [16];
    logic [15:0]       r_stall_cycles;

    logic [15:0]       w_pend;
    logic [15:0]       w_inc;
    logic [15:0]       w_dec;
    logic              w_raw;
    logic              w_sat;
    logic              w_hazard;

    // ------------------------------------------------------------------
    // Pending-write view of the scoreboard as seen by the decode sources.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_pend[i] = (r_cnt[i] != '0);
            // The retiring writer is the last one outstanding, so its value
            // can be forwarded straight from writeback.
            if (WB_BYPASS && wb_valid && (wb_rd == 4'(i)) && (r_cnt[i] == CNT_ONE)) begin
                w_pend[i] = 1'b0;
            end
        end
        if (ZERO_REG_HARDWIRED) begin
            w_pend[0] = 1'b0;
        end
    end

    assign w_raw = (id_use_rs1 & w_pend[id_rs1]) | (id_use_rs2 & w_pend[id_rs2]);

    // A further write to a register whose counter is full would overflow it.
    assign w_sat = id_write_rd & (r_cnt[id_rd] == CNT_MAX)
                 & ~(ZERO_REG_HARDWIRED && (id_rd == 4'd0));

    assign w_hazard = id_valid & (w_raw | w_sat);

    // ------------------------------------------------------------------
    // Next-state and output decode.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path leaves one unassigned, which would infer a latch.
        w_state_nxt     = r_state;
        w_flush_rem_nxt = r_flush_rem;
        issue           = 1'b0;
        bubble          = 1'b1;
        pc_write        = 1'b1;
        ir_write        = 1'b1;
        ir_flush        = 1'b0;

        if (flush_req) begin
            // Redirect wins over any hazard: load the target into the PC and
            // clear the IR; the counter restarts on every new request.
            ir_write = 1'b0;
            ir_flush = 1'b1;
            if (FLUSH_CYCLES == 1) begin
                w_state_nxt     = ST_RUN;
                w_flush_rem_nxt = 4'd0;
            end else begin
                w_state_nxt     = ST_FLUSH;
                w_flush_rem_nxt = FLUSH_INIT;
            end
        end else if (r_state == ST_FLUSH) begin
            ir_write = 1'b0;
            ir_flush = 1'b1;
            if (r_flush_rem <= 4'd1) begin
                w_state_nxt     = ST_RUN;
                w_flush_rem_nxt = 4'd0;
            end else begin
                w_flush_rem_nxt = r_flush_rem - 4'd1;
            end
        end else begin
            issue       = id_valid & ~w_hazard;
            bubble      = ~issue;
            pc_write    = ~w_hazard;
            ir_write    = ~w_hazard;
            w_state_nxt = w_hazard ? ST_STALL : ST_RUN;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard counter update. Runs every cycle, including during a flush,
    // because squashed writers still retire through wb_valid.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_inc[i] = issue & id_write_rd & (id_rd == 4'(i))
                     & ~(ZERO_REG_HARDWIRED && (i == 0));
            w_dec[i] = wb_valid & (wb_rd == 4'(i)) & (r_cnt[i] != '0);
            w_cnt_nxt[i] = r_cnt[i];
            if (w_inc[i] && !w_dec[i]) begin
                w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
            end else if (w_dec[i] && !w_inc[i]) begin
                w_cnt_nxt[i] = r_cnt[i] - CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            r_state        <= ST_RUN;
            r_flush_rem    <= 4'd0;
            r_stall_cycles <= 16'd0;
            // NOTE: the counter array is 16 small flops, not a RAM, so it can
            // and must be cleared by reset to start with an empty scoreboard.
            for (int i = 0; i < 16; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_flush_rem <= w_flush_rem_nxt;
            for (int i = 0; i < 16; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            if (w_hazard && !flush_req && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            busy_vec[i] = (r_cnt[i] != '0);
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign state        = r_state;

endmodule

// File: doc/decode_hazard_scheduler.md
Name: decode_hazard_scheduler

Overview:
- Issue controller for the decode stage of the 16-bit pipeline.
- Keeps a per-register scoreboard of in-flight writes to the 16-entry register file.
- Stalls the PC/IR and injects bubbles on RAW hazards and on write-count saturation.
- Sequences pipeline flushes on redirect and exports a saturating stall-cycle performance counter.

Parameters:
- CNT_W, 2: width of each per-register outstanding-write counter; max outstanding writes per register = 2^CNT_W-1.
- FLUSH_CYCLES, 2: number of cycles ir_flush is held after a redirect, including the request cycle; legal range 1-15.
- ZERO_REG_HARDWIRED, 1: when 1, r0 is never tracked, never causes a hazard, and never increments a counter.
- WB_BYPASS, 0: when 1, a writeback to a source register in the current cycle satisfies that source.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  decode stage holds a valid instruction.
- id_rs1  in  4  source register 1 field.
- id_rs2  in  4  source register 2 field.
- id_rd  in  4  destination register field.
- id_use_rs1  in  1  instruction reads rs1.
- id_use_rs2  in  1  instruction reads rs2.
- id_write_rd  in  1  instruction writes rd.
- wb_valid  in  1  an issued writer retires this cycle; also asserted for squashed writers.
- wb_rd  in  4  destination of the retiring writer.
- flush_req  in  1  one-cycle redirect request from execute.
- pc_write  out  1  PC register enable.
- ir_write  out  1  IR register enable.
- issue  out  1  decode instruction advances to execute this cycle.
- bubble  out  1  insert a NOP into decode/execute this cycle.
- ir_flush  out  1  clear the IR to NOP.
- busy_vec  out  16  bit i = counter[i] != 0.
- stall_cycles  out  16  hazard-stall cycle count.
- state  out  2  0=RUN, 1=STALL, 2=FLUSH.

Behaviour:
- Reset is synchronous and active-high; the single clock is clk.
- While rst=1 at an edge: all counters go to 0, state goes to RUN, flush counter goes to 0, stall_cycles goes to 0. Reset mid-flush or mid-stall abandons that operation.
- All outputs except state, busy_vec and stall_cycles are combinational from the current state and inputs.
- Reset output values: state=0, busy_vec=0, stall_cycles=0. With id_valid=0: issue=0, bubble=1, pc_write=1, ir_write=1, ir_flush=0.
- pend(r) = (counter[r] != 0).
  - pend(0) is forced to 0 when ZERO_REG_HARDWIRED=1.
  - When WB_BYPASS=1, pend(r) is also 0 if wb_valid & wb_rd==r & counter[r]==1.
- raw = (id_use_rs1 & pend(id_rs1)) | (id_use_rs2 & pend(id_rs2)).
- sat = id_write_rd & counter[id_rd]==max; sat is ignored for tracked-out r0.
- hazard = id_valid & (raw | sat).
- flush_req has priority over everything except rst.
  - In any state it gives: issue=0, bubble=1, ir_flush=1, pc_write=1 (load redirect target), ir_write=0.
  - Next state is FLUSH with remaining = FLUSH_CYCLES-1. If FLUSH_CYCLES=1, next state is RUN.
- FLUSH state:
  - Outputs: ir_flush=1, bubble=1, issue=0, pc_write=1, ir_write=0.
  - remaining decrements each cycle; at remaining==1 the next state is RUN.
  - A new flush_req restarts the count.
- RUN/STALL state, no flush:
  - issue = id_valid & !hazard.
  - bubble = !issue.
  - pc_write = ir_write = !hazard.
  - ir_flush = 0.
  - Next state is STALL if hazard, else RUN.
- stall_cycles increments by 1 on every cycle with hazard=1 and no flush_req, saturating at 0xFFFF.
- Counter update per register r, applied every cycle including during FLUSH:
  - inc = issue & id_write_rd & id_rd==r (r0 excluded when hardwired).
  - dec = wb_valid & wb_rd==r & counter[r]!=0.
  - Net effect is counter + inc - dec. Simultaneous inc and dec on the same register leaves it unchanged.
  - A dec on a zero counter is ignored (no underflow). inc never exceeds max, because sat blocks issue.
- The scoreboard is not cleared by flush. Squashed in-flight writers must still retire via wb_valid, so their counters drain normally.

Test Plan:
1. Reset, then id_valid=1, rs1=3 used, rd=5 write, scoreboard empty -> issue=1, pc_write=1; next cycle busy_vec=0x0020.
2. counter[5]=1, then issue an instruction reading rs1=5 -> issue=0, bubble=1, pc_write=0, state->STALL, stall_cycles increments each cycle. After wb_valid with wb_rd=5, the next cycle gives issue=1 and state=RUN. With WB_BYPASS=1, issue=1 in the writeback cycle itself.
3. CNT_W=2, issue three writers of r7 with no writeback -> busy_vec bit7=1, a fourth writer is stalled. One writeback then allows issue. A simultaneous issue-and-writeback on r7 keeps the counter unchanged.
4. Writer of r0 with source r0 while ZERO_REG_HARDWIRED=1 -> issue every cycle, busy_vec stays 0x0000.
5. flush_req during STALL with FLUSH_CYCLES=2 -> ir_flush=1 for 2 cycles, issue=0, pc_write=1, then RUN. counter values persist until their wb_valid pulses arrive.
6. Assert rst during FLUSH with busy_vec=0x00F0 and stall_cycles=9 -> next cycle state=0, busy_vec=0, stall_cycles=0. Force 0x10000 hazard cycles -> stall_cycles holds at 0xFFFF.
